// File: rtl/jstk_spi_responder_if.sv
// SPI pin bundle between a PmodJSTK-style master and the joystick responder.
// The master drives mode-0 sclk/ss/mosi, and the slave returns miso plus a tristate enable.
`timescale 1ns/1ps
interface jstk_spi_responder_if;
    logic sclk;
    logic ss;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (output sclk, output ss, output mosi, input miso, input miso_oe);
    modport slave  (input sclk, input ss, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/jstk_spi_responder.sv
// PmodJSTK emulator: answers 5-byte mode-0 SPI frames with an X/Y/button snapshot
// and takes the LED bits from a valid first command byte.
`timescale 1ns/1ps
module jstk_spi_responder #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    jstk_spi_responder_if.slave        spi,
    input  logic [9:0]                 x_pos,
    input  logic [9:0]                 y_pos,
    input  logic [2:0]                 buttons,
    output logic [1:0]                 led,
    output logic                       frame_done,
    output logic                       frame_abort
);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, ss_prev_q;
    logic                   sclk_s, ss_s, mosi_s;
    logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic [39:0]            snapshot;
    logic [39:0]            tx_q, tx_d;
    logic [7:0]             rx_q, rx_d;
    logic [5:0]             cnt_q, cnt_d;
    logic                   pend_q, pend_d;
    logic                   miso_q, miso_d, oe_q, oe_d;
    logic [1:0]             led_q, led_d;
    logic                   done_q, done_d, abort_q, abort_d;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign ss_rise   = ss_s & ~ss_prev_q;
    assign ss_fall   = ~ss_s & ss_prev_q;

    assign snapshot = {x_pos[7:0], 6'b0, x_pos[9:8], y_pos[7:0], 6'b0, y_pos[9:8], 5'b0, buttons};

    assign spi.miso    = miso_q;
    assign spi.miso_oe = oe_q;
    assign led         = led_q;
    assign frame_done  = done_q;
    assign frame_abort = abort_q;

    // ss chain resets low so an ss held low across reset release never looks like a fall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b0;
            state_q     <= S_IDLE;
            tx_q        <= '0;
            rx_q        <= '0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            led_q       <= '0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi.ss};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
            sclk_prev_q <= sclk_s;
            ss_prev_q   <= ss_s;
            state_q     <= state_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            led_q       <= led_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        miso_d  = miso_q;
        oe_d    = oe_q;
        led_d   = led_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                miso_d = 1'b0;
                oe_d   = 1'b0;
                if (ss_fall || (pend_q && !ss_s)) begin
                    pend_d  = 1'b0;
                    state_d = S_SHIFT;
                    tx_d    = snapshot;
                    miso_d  = snapshot[39];
                    oe_d    = 1'b1;
                    cnt_d   = '0;
                    rx_d    = '0;
                end else begin
                    pend_d = 1'b0;
                end
            end
            S_SHIFT: begin
                if (ss_rise) begin
                    state_d = S_DONE;
                    oe_d    = 1'b0;
                    miso_d  = 1'b0;
                end else begin
                    if (sclk_rise) begin
                        rx_d = {rx_q[6:0], mosi_s};
                        if (cnt_q != 6'd40) cnt_d = cnt_q + 6'd1;
                        // Only the first byte can carry a command; 0b100000xy selects the LEDs
                        if (cnt_q == 6'd7 && rx_d[7:2] == 6'b100000) led_d = rx_d[1:0];
                    end
                    if (sclk_fall) begin
                        tx_d   = {tx_q[38:0], 1'b0};
                        miso_d = tx_q[38];
                    end
                end
            end
            S_DONE: begin
                done_d  = (cnt_q >= 6'd40);
                abort_d = (cnt_q < 6'd40);
                state_d = S_IDLE;
                pend_d  = ss_fall;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_jstk_spi_responder.sv
// Bench for jstk_spi_responder: table of frames played by a mode-0 master, MISO bytes
// checked against a scoreboard queue, plus a hand-written mid-frame reset sequence.
`timescale 1ns/1ps
module tb_jstk_spi_responder;
    localparam int HALF = 50;  // 1 MHz SCLK with a 100 MHz clk

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] btn;
        logic [7:0] cmd;
        int         nbits;
        int         chg_bit;
        logic [9:0] chg_x;
        logic [1:0] exp_led;
        logic       exp_done;
        logic       exp_abort;
    } frame_vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] x_pos, y_pos;
    logic [2:0] buttons;
    logic [1:0] led;
    logic       frame_done, frame_abort;

    jstk_spi_responder_if spi ();

    jstk_spi_responder #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .spi        (spi),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .buttons    (buttons),
        .led        (led),
        .frame_done (frame_done),
        .frame_abort(frame_abort)
    );

    always #5 clk = ~clk;

    int errors  = 0;
    int nchecks = 0;
    int done_cnt  = 0;
    int abort_cnt = 0;
    logic [7:0] exp_q [$];
    frame_vec_t vecs [7];

    always @(negedge clk) begin
        if (frame_done)  done_cnt  <= done_cnt + 1;
        if (frame_abort) abort_cnt <= abort_cnt + 1;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic sb_check(input logic [7:0] got);
        if (exp_q.size() == 0) begin
            nchecks++;
            errors++;
            $display("FAIL sb_underflow: got %h required no byte", got);
        end else begin
            check("miso_byte", {24'h0, got}, {24'h0, exp_q.pop_front()});
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_xfer(input logic mo, output logic mi);
        spi.mosi = mo;
        clk_n(HALF);
        spi.sclk = 1'b1;
        mi = spi.miso;
        clk_n(HALF);
        spi.sclk = 1'b0;
    endtask

    function automatic logic [39:0] frame_of(input logic [9:0] x, input logic [9:0] y, input logic [2:0] b);
        return {x[7:0], 6'b0, x[9:8], y[7:0], 6'b0, y[9:8], 5'b0, b};
    endfunction

    task automatic run_frame(input frame_vec_t v);
        logic [39:0] fr;
        logic [7:0]  rxb;
        logic [7:0]  cmd;
        logic        mi;
        int          d0, a0;
        x_pos   = v.x;
        y_pos   = v.y;
        buttons = v.btn;
        cmd     = v.cmd;
        fr      = frame_of(v.x, v.y, v.btn);
        for (int i = 0; i < v.nbits / 8; i++)
            exp_q.push_back(i < 5 ? fr[39 - 8*i -: 8] : 8'h00);
        d0 = done_cnt;
        a0 = abort_cnt;
        rxb = '0;
        spi.ss = 1'b0;
        clk_n(2);
        check("oe_before_latency", {31'h0, spi.miso_oe}, 32'h0);
        clk_n(1);
        check("oe_after_ss_fall", {31'h0, spi.miso_oe}, 32'h1);
        clk_n(HALF - 3);
        for (int b = 0; b < v.nbits; b++) begin
            if (b == v.chg_bit) x_pos = v.chg_x;
            bit_xfer(b < 8 ? cmd[7 - b] : 1'b0, mi);
            rxb = {rxb[6:0], mi};
            if (b % 8 == 7) sb_check(rxb);
            if (b == 7) check("led_after_byte0", {30'h0, led}, {30'h0, v.exp_led});
        end
        clk_n(HALF);
        spi.ss = 1'b1;
        clk_n(2);
        check("oe_held_after_ss_rise", {31'h0, spi.miso_oe}, 32'h1);
        clk_n(1);
        check("oe_drop_after_ss_rise", {31'h0, spi.miso_oe}, 32'h0);
        clk_n(1);
        check("pulse_timing", {30'h0, frame_done, frame_abort}, {30'h0, v.exp_done, v.exp_abort});
        clk_n(6);
        check("done_count", done_cnt - d0, {31'h0, v.exp_done});
        check("abort_count", abort_cnt - a0, {31'h0, v.exp_abort});
    endtask

    initial begin
        logic [39:0] fr;
        logic [7:0]  rxb;
        logic [7:0]  cmd83;
        logic        mi;
        int          d0, a0;
        frame_vec_t  post;

        vecs[0] = '{10'h2A5, 10'h13C, 3'b101, 8'h83, 40, -1, 10'h000, 2'b11, 1'b1, 1'b0};
        vecs[1] = '{10'h2A5, 10'h13C, 3'b101, 8'h00, 40, 12, 10'h000, 2'b11, 1'b1, 1'b0};
        vecs[2] = '{10'h000, 10'h13C, 3'b101, 8'h81, 40, -1, 10'h000, 2'b01, 1'b1, 1'b0};
        vecs[3] = '{10'h000, 10'h13C, 3'b101, 8'h42, 40, -1, 10'h000, 2'b01, 1'b1, 1'b0};
        vecs[4] = '{10'h2A5, 10'h13C, 3'b101, 8'h00, 17, -1, 10'h000, 2'b01, 1'b0, 1'b1};
        vecs[5] = '{10'h3FF, 10'h200, 3'b010, 8'h80, 40, -1, 10'h000, 2'b00, 1'b1, 1'b0};
        vecs[6] = '{10'h155, 10'h0AA, 3'b111, 8'h83, 48, -1, 10'h000, 2'b11, 1'b1, 1'b0};

        rst = 1'b1;
        spi.sclk = 1'b0;
        spi.ss   = 1'b1;
        spi.mosi = 1'b0;
        x_pos = '0;
        y_pos = '0;
        buttons = '0;
        clk_n(5);
        check("reset_values", {25'h0, spi.miso, spi.miso_oe, led, frame_done, frame_abort}, 32'h0);
        rst = 1'b0;
        clk_n(5);

        foreach (vecs[i]) run_frame(vecs[i]);

        // Mid-frame reset during byte 2 with ss held low through release
        cmd83 = 8'h83;
        x_pos = 10'h2A5;
        y_pos = 10'h13C;
        buttons = 3'b101;
        fr = frame_of(x_pos, y_pos, buttons);
        exp_q.push_back(fr[39:32]);
        exp_q.push_back(fr[31:24]);
        d0 = done_cnt;
        a0 = abort_cnt;
        rxb = '0;
        spi.ss = 1'b0;
        clk_n(HALF);
        for (int b = 0; b < 20; b++) begin
            bit_xfer(b < 8 ? cmd83[7 - b] : 1'b0, mi);
            rxb = {rxb[6:0], mi};
            if (b % 8 == 7) sb_check(rxb);
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            clk_n(1);
            check("outputs_in_reset", {26'h0, spi.miso, spi.miso_oe, led, frame_done, frame_abort}, 32'h0);
        end
        rst = 1'b0;
        for (int b = 0; b < 8; b++) begin
            bit_xfer(cmd83[7 - b], mi);
            check("quiet_after_reset", {30'h0, mi, spi.miso_oe}, 32'h0);
        end
        check("led_after_reset", {30'h0, led}, 32'h0);
        spi.ss = 1'b1;
        clk_n(10);
        check("no_pulse_reset_done", done_cnt - d0, 32'h0);
        check("no_pulse_reset_abort", abort_cnt - a0, 32'h0);

        post = '{10'h1C3, 10'h3A7, 3'b011, 8'h82, 40, -1, 10'h000, 2'b10, 1'b1, 1'b0};
        run_frame(post);

        check("scoreboard_empty", exp_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, nchecks);
        $finish;
    end
endmodule
